// File: rtl/record_field_scheduler_if.sv
// Bundle of requester write ports, init/commit control and the committed
// snapshot outputs for record_field_scheduler.
interface record_field_scheduler_if #(
    parameter int NREQ   = 4,
    parameter int NFIELD = 16,
    parameter int FW     = 8,
    parameter int IDXW   = 4
);
    logic [NREQ-1:0]      req;
    logic [NREQ*IDXW-1:0] req_idx;
    logic [NREQ*FW-1:0]   req_data;
    logic [NREQ-1:0]      gnt;
    logic                 init_req;
    logic                 commit_req;
    logic                 commit_ack;
    logic [NFIELD*FW-1:0] rec_out;
    logic                 rec_valid;
    logic                 err_idx;

    modport master (
        output req, req_idx, req_data, init_req, commit_req,
        input  gnt, commit_ack, rec_out, rec_valid, err_idx
    );

    modport slave (
        input  req, req_idx, req_data, init_req, commit_req,
        output gnt, commit_ack, rec_out, rec_valid, err_idx
    );
endinterface

// File: rtl/record_field_scheduler.sv
// Shared packed record with round-robin single-field writers, default reload
// and a commit path that copies the record into a stable output snapshot.
module record_field_scheduler #(
    parameter int NREQ   = 4,
    parameter int NFIELD = 16,
    parameter int FW     = 8,
    parameter int IDXW   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    record_field_scheduler_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_INIT, S_RUN, S_COMMIT} state_t;

    state_t                   state, state_n;
    logic [PW-1:0]            rr_ptr;
    logic [NFIELD-1:0][FW-1:0] rec;
    logic [NFIELD-1:0][FW-1:0] snap;
    logic                     rec_valid;
    logic                     err_idx;
    logic [NREQ-1:0]          gnt;
    logic                     found;
    logic [PW-1:0]            win;
    logic [IDXW-1:0]          w_idx;
    logic [FW-1:0]            w_data;
    logic                     idx_ok;

    // Rotating scan starting at rr_ptr; init_req suppresses granting entirely.
    always_comb begin
        gnt    = '0;
        found  = 1'b0;
        win    = '0;
        w_idx  = '0;
        w_data = '0;
        idx_ok = 1'b0;
        if (state == S_RUN && !bus.init_req) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!found && bus.req[(32'(rr_ptr) + i) % NREQ]) begin
                    found = 1'b1;
                    win   = PW'((32'(rr_ptr) + i) % NREQ);
                end
            end
            if (found) begin
                gnt[win] = 1'b1;
            end
        end
        w_idx  = bus.req_idx[32'(win)*IDXW +: IDXW];
        w_data = bus.req_data[32'(win)*FW +: FW];
        idx_ok = (32'(w_idx) < NFIELD);
    end

    always_comb begin
        state_n = state;
        case (state)
            S_INIT:   state_n = S_RUN;
            S_RUN: begin
                if (bus.init_req)        state_n = S_INIT;
                else if (bus.commit_req) state_n = S_COMMIT;
            end
            S_COMMIT: state_n = S_RUN;
            default:  state_n = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_INIT;
            rec       <= '0;
            rr_ptr    <= '0;
            snap      <= '0;
            rec_valid <= 1'b0;
            err_idx   <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                S_INIT: begin
                    for (int unsigned k = 0; k < NFIELD; k++) begin
                        rec[k] <= FW'(k);
                    end
                end
                S_RUN: begin
                    if (found) begin
                        rr_ptr <= PW'((32'(win) + 1) % NREQ);
                        if (!idx_ok) begin
                            err_idx <= 1'b1;
                        end
                        // Equality match keeps the write in range for any NFIELD/IDXW pairing.
                        for (int unsigned k = 0; k < NFIELD; k++) begin
                            if (w_idx == IDXW'(k)) begin
                                rec[k] <= w_data;
                            end
                        end
                    end
                end
                S_COMMIT: begin
                    snap      <= rec;
                    rec_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt        = gnt;
    assign bus.commit_ack = (state == S_COMMIT);
    assign bus.rec_out    = snap;
    assign bus.rec_valid  = rec_valid;
    assign bus.err_idx    = err_idx;
endmodule
